fetch_unit: RTL

Instruction fetch stage of the 16-bit single-cycle RISC core, directly upstream of the control unit. Holds the program counter and fetches one 16-bit instruction word per instruction from instruction memory over a req/ack handshake. Presents the instruction (opcode in bits 15:12) to decode. Computes the next PC from the control unit's `jump`/`jeq`/`jr` outputs when execute signals completion.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 14 +
 rtl/pc_next.sv | 35 +++
 rtl/fetch_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle RISC core: widths,
// opcode encodings, fetch FSM states and a small sign-extension helper.
package cpu_pkg;

    localparam int XLEN = 16;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JEQ = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_JR  = 4'b1011;
    localparam logic [3:0] OP_SUB = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

    // Sign-extend a 4-bit branch offset to the machine width.
    function automatic logic [XLEN-1:0] sext4(input logic [3:0] v);
        return {{(XLEN-4){v[3]}}, v};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_unit_if;

    logic                      imem_req;
    logic [cpu_pkg::XLEN-1:0]  imem_addr;
    logic                      imem_ack;
    logic [cpu_pkg::XLEN-1:0]  imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selection: jr, then jump, then taken jeq, else pc+1.
// All arithmetic is modulo 2^XLEN.
module pc_next
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            jump,
    input  logic            jeq,
    input  logic            jr,
    input  logic            zero,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] pc_inc;
    logic            unused_opcode;

    assign pc_inc        = pc + 16'd1;
    assign unused_opcode = ^instr[15:12];

    // Priority redirect mux; first matching control wins.
    always_comb begin
        // NOTE: next_pc gets a value on every path (default first), so no latch is inferred.
        next_pc = pc_inc;
        if (jr) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = {pc[15:12], instr[11:0]};
        end else if (jeq && zero) begin
            next_pc = pc_inc + sext4(instr[3:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction
// over the imem req/ack bus, presents it to decode and advances the PC when
// execute retires the instruction.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    input  logic            ex_done,
    input  logic            jump,
    input  logic            jeq,
    input  logic            jr,
    input  logic            zero,
    input  logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] retired
);

    fetch_state_e    state_q, state_d;
    logic            instr_load;
    logic            retire;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] retired_q;
    logic [XLEN-1:0] next_pc;

    pc_next u_pc_next (
        .pc      (pc_q),
        .instr   (instr_q),
        .rs_data (rs_data),
        .jump    (jump),
        .jeq     (jeq),
        .jr      (jr),
        .zero    (zero),
        .next_pc (next_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses <= so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the load/retire strobes; ack and ex_done only matter in their own state.
    always_comb begin
        state_d    = state_q;
        instr_load = 1'b0;
        retire     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    instr_load = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ex_done) begin
                    retire  = 1'b1;
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PC, instruction register and retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            if (instr_load) instr_q <= imem.imem_rdata;
            if (retire) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ST_ISSUE);
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign retired        = retired_q;

endmodule
